cam_reg_sequencer: RTL and testbench

//  Parametrised successor to the single-camera register-table walker. Walks one register table once per camera
//  (NUM_CAMS sensors sharing one SCCB master), and issues each entry through a valid/ready command handshake.

---
 rtl/cam_reg_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_cam_reg_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_reg_sequencer.sv
// Multi-camera SCCB register-table walker: replays one ROM table per camera through a
// valid/ready command port, waiting for each response, retrying NACKs and executing inline delays.
module cam_reg_sequencer #(
    parameter int unsigned       NUM_CAMS  = 2,
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       REG_W     = 8,
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       CLK_HZ    = 25000000,
    parameter logic [REG_W-1:0]  DELAY_TAG = 8'hF0,
    parameter int unsigned       MAX_RETRY = 3,
    localparam int unsigned      CAM_W     = (NUM_CAMS > 1) ? $clog2(NUM_CAMS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [REG_W+DATA_W-1:0] rom_data,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [CAM_W-1:0]        cmd_cam,
    output logic [REG_W-1:0]        cmd_reg,
    output logic [DATA_W-1:0]       cmd_data,
    input  logic                    resp_valid,
    input  logic                    resp_err,
    output logic                    busy,
    output logic [NUM_CAMS-1:0]     cam_done,
    output logic                    done,
    output logic                    error
);

    localparam int unsigned       ENTRY_W  = REG_W + DATA_W;
    localparam int unsigned       TICKS    = CLK_HZ / 1000;
    localparam longint unsigned   DLY_MAX  = ((64'd1 << DATA_W) - 64'd1) * 64'(TICKS);
    localparam int unsigned       DLY_W    = (DLY_MAX > 0) ? $clog2(DLY_MAX + 64'd1) : 1;
    localparam int unsigned       RTRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;
    localparam logic [CAM_W-1:0]  LAST_CAM = CAM_W'(NUM_CAMS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_RESP,
        S_DELAY,
        S_NEXT_CAM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                valid_d;
    logic [CAM_W-1:0]    cam_d;
    logic [REG_W-1:0]    reg_d;
    logic [DATA_W-1:0]   data_d;
    logic                busy_d;
    logic [NUM_CAMS-1:0] cam_done_d;
    logic                done_d;
    logic                error_d;
    logic [RTRY_W-1:0]   retry_q, retry_d;
    logic [DLY_W-1:0]    dly_q, dly_d;

    logic [REG_W-1:0]    entry_reg;
    logic [DATA_W-1:0]   entry_data;
    logic [DLY_W-1:0]    dly_load;
    logic                last_idx;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rom_addr  <= '0;
            cmd_valid <= 1'b0;
            cmd_cam   <= '0;
            cmd_reg   <= '0;
            cmd_data  <= '0;
            busy      <= 1'b0;
            cam_done  <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            retry_q   <= '0;
            dly_q     <= '0;
        end else begin
            state_q   <= state_d;
            rom_addr  <= addr_d;
            cmd_valid <= valid_d;
            cmd_cam   <= cam_d;
            cmd_reg   <= reg_d;
            cmd_data  <= data_d;
            busy      <= busy_d;
            cam_done  <= cam_done_d;
            done      <= done_d;
            error     <= error_d;
            retry_q   <= retry_d;
            dly_q     <= dly_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        addr_d     = rom_addr;
        valid_d    = cmd_valid;
        cam_d      = cmd_cam;
        reg_d      = cmd_reg;
        data_d     = cmd_data;
        cam_done_d = cam_done;
        done_d     = done;
        error_d    = error;
        retry_d    = retry_q;
        dly_d      = dly_q;

        entry_reg  = rom_data[ENTRY_W-1:DATA_W];
        entry_data = rom_data[DATA_W-1:0];
        dly_load   = DLY_W'(entry_data) * DLY_W'(TICKS);
        last_idx   = (rom_addr == LAST_IDX);

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    cam_done_d = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    cam_d      = '0;
                    addr_d     = '0;
                    retry_d    = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (rom_data == '1) begin
                    state_d = S_NEXT_CAM;
                end else if (entry_reg == DELAY_TAG) begin
                    dly_d   = (dly_load == '0) ? DLY_W'(1) : dly_load;
                    state_d = S_DELAY;
                end else begin
                    reg_d   = entry_reg;
                    data_d  = entry_data;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    valid_d = 1'b0;
                    state_d = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (resp_valid) begin
                    if (!resp_err) begin
                        retry_d = '0;
                        // Last table slot without an end tag ends this camera instead of wrapping
                        state_d = last_idx ? S_NEXT_CAM : S_FETCH;
                        addr_d  = last_idx ? rom_addr : rom_addr + ADDR_W'(1);
                    end else if (retry_q < RTRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RTRY_W'(1);
                        valid_d = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_ERROR;
                    end
                end
            end
            S_DELAY: begin
                if (dly_q <= DLY_W'(1)) begin
                    state_d = last_idx ? S_NEXT_CAM : S_FETCH;
                    addr_d  = last_idx ? rom_addr : rom_addr + ADDR_W'(1);
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            S_NEXT_CAM: begin
                cam_done_d[cmd_cam] = 1'b1;
                if (cmd_cam == LAST_CAM) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cam_d   = cmd_cam + CAM_W'(1);
                    addr_d  = '0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = !(state_d inside {S_IDLE, S_DONE, S_ERROR});
    end

endmodule

// File: tb/tb_cam_reg_sequencer.sv
// Scoreboard bench for cam_reg_sequencer: a table-walking reference model predicts every command,
// its issue latency and the camera progress; a monitor pops and compares on each transfer.
module tb_cam_reg_sequencer;

    localparam int NC    = 2;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int MR    = 3;
    localparam logic [7:0] TAG = 8'hF0;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [AW-1:0] rom_addr;
    logic [15:0] rom_data;
    logic        cmd_valid, cmd_ready;
    logic [0:0]  cmd_cam;
    logic [7:0]  cmd_reg, cmd_data;
    logic        resp_valid, resp_err;
    logic        busy, done, error;
    logic [NC-1:0] cam_done;

    cam_reg_sequencer #(
        .NUM_CAMS(NC), .ADDR_W(AW), .REG_W(8), .DATA_W(8),
        .CLK_HZ(1000), .DELAY_TAG(TAG), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_cam(cmd_cam), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .resp_valid(resp_valid), .resp_err(resp_err),
        .busy(busy), .cam_done(cam_done), .done(done), .error(error)
    );

    typedef struct {
        int cam;
        int rg;
        int dat;
        int lat;
        int cdone;
    } exp_t;

    exp_t q[$];
    logic [15:0] rom [DEPTH];
    int nack  [NC][DEPTH];
    int tries [NC][DEPTH];
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, trig = 0;
    bit hold_ready = 1'b0;
    int ready_pct = 100;
    bit exp_error;
    int err_cam, err_reg;

    initial forever begin
        #5 clk = 1'b1;
        cyc++;
        #5 clk = 1'b0;
    end

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic mark_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not expected/observed (t=%0t)", name, $time);
    endtask

    // Reference: walk the table per camera from the rules, tracking the cycle of the next fetch
    // relative to the most recent trigger (start pulse or response)
    function automatic void build_model();
        int f;
        exp_error = 1'b0;
        f = 1;
        for (int c = 0; c < NC; c++) begin
            int idx;
            bit fin;
            idx = 0;
            fin = 1'b0;
            while (!fin) begin
                logic [15:0] e;
                e = rom[idx];
                if (e == 16'hFFFF) begin
                    f += 3;
                    fin = 1'b1;
                end else if (e[15:8] == TAG) begin
                    f += 2 + ((e[7:0] == 0) ? 1 : int'(e[7:0]));
                    if (idx == DEPTH - 1) begin f += 1; fin = 1'b1; end
                    else idx++;
                end else begin
                    int att;
                    att = (nack[c][idx] > MR) ? MR + 1 : nack[c][idx] + 1;
                    for (int t = 0; t < att; t++)
                        q.push_back('{cam: c, rg: int'(e[15:8]), dat: int'(e[7:0]),
                                      lat: (t == 0) ? f + 2 : 1, cdone: (1 << c) - 1});
                    if (nack[c][idx] > MR) begin
                        exp_error = 1'b1;
                        err_cam = c;
                        err_reg = int'(e[15:8]);
                        return;
                    end
                    f = 1;
                    if (idx == DEPTH - 1) begin f += 1; fin = 1'b1; end
                    else idx++;
                end
            end
        end
    endfunction

    function automatic void clear_plan();
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < DEPTH; i++) begin
                nack[c][i] = 0;
                tries[c][i] = 0;
            end
        for (int i = 0; i < DEPTH; i++) rom[i] = 16'hFFFF;
    endfunction

    function automatic void rand_table(input bit no_end);
        int len;
        len = no_end ? DEPTH : $urandom_range(0, 10);
        clear_plan();
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 9) < 2)
                rom[i] = {TAG, 8'($urandom_range(0, 5))};
            else
                rom[i] = {8'($urandom_range(0, 8'hEF)), 8'($urandom_range(0, 255))};
            for (int c = 0; c < NC; c++) begin
                int r;
                r = $urandom_range(0, 59);
                nack[c][i] = (r == 0) ? MR + 1 : (r < 8) ? $urandom_range(1, MR) : 0;
            end
        end
    endfunction

    // Ready generator
    initial begin
        cmd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 cmd_ready = hold_ready ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
        end
    end

    // SCCB responder: NACKs the first nack[cam][idx] attempts of each entry
    initial begin : responder
        int c, a, d;
        bit e;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_valid && cmd_ready && !reset) begin
                c = int'(cmd_cam);
                a = int'(rom_addr);
                d = $urandom_range(0, 4);
                tries[c][a]++;
                e = (tries[c][a] <= nack[c][a]);
                @(posedge clk);
                repeat (d) @(posedge clk);
                #1;
                resp_valid = 1'b1;
                resp_err   = e;
                trig       = cyc;
                @(posedge clk);
                #1;
                resp_valid = 1'b0;
                resp_err   = 1'b0;
            end
        end
    end

    // Monitor: latency/progress at each new offer, payload on each transfer, stability while stalled
    initial begin : monitor
        bit pv, pstall;
        logic [16:0] ppay;
        exp_t e;
        pv = 1'b0;
        pstall = 1'b0;
        ppay = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 1'b0;
                pstall = 1'b0;
            end else begin
                if (cmd_valid && pstall)
                    check("stall_payload_stable", {cmd_cam, cmd_reg, cmd_data}, ppay);
                if (cmd_valid && !pv) begin
                    if (q.size() == 0) mark_fail("issue_unexpected");
                    else begin
                        check("issue_latency", cyc - trig, q[0].lat);
                        check("cam_done_at_issue", cam_done, q[0].cdone);
                    end
                end
                if (cmd_valid && cmd_ready) begin
                    if (q.size() == 0) mark_fail("transfer_unexpected");
                    else begin
                        e = q.pop_front();
                        check("cmd_word", {cmd_cam, cmd_reg, cmd_data},
                              {1'(e.cam), 8'(e.rg), 8'(e.dat)});
                    end
                end
                pstall = cmd_valid && !cmd_ready;
                ppay   = {cmd_cam, cmd_reg, cmd_data};
                pv     = cmd_valid;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              {rom_addr, cmd_valid, cmd_cam, cmd_reg, cmd_data, busy, cam_done, done, error}, 0);
    endtask

    task automatic run_seq(input int pct, input bit stall, input bit poke);
        q.delete();
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < DEPTH; i++) tries[c][i] = 0;
        build_model();
        ready_pct  = pct;
        hold_ready = stall;
        @(posedge clk);
        #1 start = 1'b1;
        trig = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("start_rom_addr", rom_addr, 0);
        check("start_busy", busy, 1);
        if (stall) begin
            for (int i = 0; i < 50 && !cmd_valid; i++) @(negedge clk);
            repeat (10) @(posedge clk);
            #1 hold_ready = 1'b0;
        end
        if (poke) begin
            repeat ($urandom_range(3, 15)) @(posedge clk);
            #1 if (busy) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        for (int i = 0; i < 6000 && !(done || error); i++) @(negedge clk);
        if (!(done || error)) begin
            mark_fail("run_timeout");
            do_reset();
        end else begin
            repeat (2) @(negedge clk);
            check("end_done", done, !exp_error);
            check("end_error", error, exp_error);
            check("end_busy", busy, 0);
            check("end_queue_empty", q.size(), 0);
            check("end_cam_done", cam_done, exp_error ? (1 << err_cam) - 1 : (1 << NC) - 1);
            if (exp_error) begin
                check("err_cmd_reg", cmd_reg, err_reg);
                check("err_cmd_cam", cmd_cam, err_cam);
            end
        end
    endtask

    // Start a run and hit reset while it is stalled in ISSUE or counting in DELAY
    task automatic abort_run(input bit in_issue);
        q.delete();
        build_model();
        hold_ready = in_issue;
        @(posedge clk);
        #1 start = 1'b1;
        trig = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        if (in_issue) begin
            for (int i = 0; i < 50 && !cmd_valid; i++) @(negedge clk);
            check("abort_in_issue", cmd_valid, 1);
        end else begin
            repeat (8) @(negedge clk);
            check("abort_in_delay", {busy, cmd_valid}, 2'b10);
        end
        do_reset();
        q.delete();
        hold_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        clear_plan();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              {rom_addr, cmd_valid, cmd_cam, cmd_reg, cmd_data, busy, cam_done, done, error}, 0);

        clear_plan();
        rom[0] = 16'h1280; rom[1] = 16'h1200;
        run_seq(100, 1'b0, 1'b0);
        run_seq(60, 1'b1, 1'b0);

        clear_plan();
        rom[0] = 16'hF002; rom[1] = 16'h1234; rom[2] = 16'hF000; rom[3] = 16'h5678;
        run_seq(100, 1'b0, 1'b0);

        clear_plan();
        rom[0] = 16'h3A04;
        nack[0][0] = 2;
        run_seq(80, 1'b0, 1'b0);
        nack[0][0] = 4;
        run_seq(80, 1'b0, 1'b0);
        nack[0][0] = 0;
        nack[1][0] = 4;
        run_seq(80, 1'b0, 1'b0);

        clear_plan();
        rom[0] = 16'hF040; rom[1] = 16'h1111; rom[2] = 16'h2222;
        run_seq(70, 1'b0, 1'b1);
        abort_run(1'b0);
        run_seq(100, 1'b0, 1'b0);
        clear_plan();
        rom[0] = 16'h4455;
        abort_run(1'b1);
        run_seq(50, 1'b0, 1'b0);

        rand_table(1'b1);
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < DEPTH; i++) nack[c][i] = 0;
        run_seq(75, 1'b0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            rand_table(r % 5 == 4);
            run_seq($urandom_range(30, 100), 1'b0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
